// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds the address-region nibbles, the MMIO offset map, the region enum and
// the region decoder used by the top level.
package dmem_pkg;

  // Default values of daddr[31:28] that select each region.
  localparam logic [3:0] RAM_NIB  = 4'h0;
  localparam logic [3:0] MMIO_NIB = 4'h8;

  // MMIO register offsets (daddr[7:0]).
  localparam logic [7:0] OFF_CYCLE_LO  = 8'h00;
  localparam logic [7:0] OFF_CYCLE_HI  = 8'h04;
  localparam logic [7:0] OFF_GPIO      = 8'h08;
  localparam logic [7:0] OFF_CONS_DATA = 8'h0C;
  localparam logic [7:0] OFF_CONS_STAT = 8'h10;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  function automatic region_e decode_region(input logic [3:0] nib,
                                            input logic [3:0] ram_nib,
                                            input logic [3:0] mmio_nib);
    if (nib == ram_nib) return REG_RAM;
    if (nib == mmio_nib) return REG_MMIO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-port and console bundle between the core/consumer and the responder.
// Ports of the bundle:
//   daddr, ddata_w, d_w, d_r : MEM-stage access (core -> responder)
//   ddata_r                  : combinational load data (responder -> core)
//   cons_data, cons_valid    : console FIFO head (responder -> consumer)
//   cons_ready               : consumer accepts the head byte (consumer -> responder)
interface dmem_responder_if;
  logic [31:0] daddr;
  logic [31:0] ddata_w;
  logic        d_w;
  logic        d_r;
  logic [31:0] ddata_r;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;

  modport master (
    output daddr, ddata_w, d_w, d_r, cons_ready,
    input  ddata_r, cons_data, cons_valid
  );

  modport slave (
    input  daddr, ddata_w, d_w, d_r, cons_ready,
    output ddata_r, cons_data, cons_valid
  );
endinterface

// File: rtl/console_fifo.sv
// Synchronous byte FIFO feeding the console consumer.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   push, push_data     : write side; a push while full is accepted only with a pop
//   ovf_clr             : clears the sticky overflow flag (a same-cycle drop wins)
//   full, empty, count  : occupancy, count ranges 0..Depth
//   overflow            : sticky, set when a push is dropped
//   valid, ready, data  : read side handshake; data is 0 while empty
module console_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     ovf_clr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count,
  output logic                     overflow,
  output logic                     valid,
  input  logic                     ready,
  output logic [Width-1:0]         data
);
  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop, accept, drop;

  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == CW'(Depth));
    valid  = ~empty;
    pop    = valid & ready;
    // When full, the slot freed by a same-cycle pop takes the new byte.
    accept = push & (~full | pop);
    drop   = push & full & ~pop;

    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = drop | (ovf_q & ~ovf_clr);

    count    = count_q;
    overflow = ovf_q;
    data     = valid ? mem[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM-stage data port.
// Decodes each access to a word RAM or an MMIO block (64-bit cycle counter with
// HI snapshot, GPIO output register, console FIFO). Loads are combinational;
// stores commit at the clock edge.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   bus        : data port and console handshake (slave side)
//   gpio_out   : GPIO output register
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [3:0]  RAM_BASE_NIB  = RAM_NIB,
  parameter logic [3:0]  MMIO_BASE_NIB = MMIO_NIB
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [31:0]       gpio_out
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [DEPTH];
  region_e       region;
  logic [AW-1:0] ram_idx;
  logic [7:0]    off;
  logic          ram_we, mmio_we, mmio_re;
  logic [63:0]   cycle_q, cycle_d;
  logic [31:0]   hi_snap_q, hi_snap_d;
  logic [31:0]   gpio_q, gpio_d;
  logic          push, ovf_clr;
  logic          fifo_full, fifo_empty, fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic [31:0]   mmio_rdata, ram_rdata;
  logic          unused_addr;

  // Byte-lane bits and the gap between index and region nibble are don't-care.
  assign unused_addr = ^bus.daddr[27:0];

  always_comb begin
    region  = decode_region(bus.daddr[31:28], RAM_BASE_NIB, MMIO_BASE_NIB);
    ram_idx = bus.daddr[AW+1:2];
    off     = bus.daddr[7:0];
    ram_we  = bus.d_w & (region == REG_RAM);
    mmio_we = bus.d_w & (region == REG_MMIO);
    mmio_re = bus.d_r & (region == REG_MMIO);
    push    = mmio_we & (off == OFF_CONS_DATA);
    ovf_clr = mmio_we & (off == OFF_CONS_STAT);
    gpio_d  = (mmio_we && off == OFF_GPIO) ? bus.ddata_w : gpio_q;
    // Reading LO freezes the upper word so a following HI read is coherent.
    hi_snap_d = (mmio_re && off == OFF_CYCLE_LO) ? cycle_q[63:32] : hi_snap_q;
    cycle_d   = cycle_q + 64'd1;
  end

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_CYCLE_LO:  mmio_rdata = cycle_q[31:0];
      OFF_CYCLE_HI:  mmio_rdata = hi_snap_q;
      OFF_GPIO:      mmio_rdata = gpio_q;
      OFF_CONS_STAT: mmio_rdata = 32'({fifo_count, fifo_full, fifo_empty, fifo_ovf});
      default:       mmio_rdata = '0;
    endcase
    ram_rdata   = ram[ram_idx];
    bus.ddata_r = '0;
    if (bus.d_r) begin
      case (region)
        REG_RAM:  bus.ddata_r = ram_rdata;
        REG_MMIO: bus.ddata_r = mmio_rdata;
        default:  bus.ddata_r = '0;
      endcase
    end
    gpio_out = gpio_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      hi_snap_q <= '0;
      gpio_q    <= '0;
    end else begin
      cycle_q   <= cycle_d;
      hi_snap_q <= hi_snap_d;
      gpio_q    <= gpio_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.ddata_w;
  end

  console_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_console_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.ddata_w[7:0]),
    .ovf_clr   (ovf_clr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf),
    .valid     (bus.cons_valid),
    .ready     (bus.cons_ready),
    .data      (bus.cons_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: RAM, same-cycle read/write, cycle
// counter with HI snapshot, GPIO, console FIFO overflow and drain, full FIFO
// with simultaneous pop/push, and reset during a drain.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] MMIO   = 32'h8000_0000;
  localparam logic [31:0] A_LO   = MMIO | 32'(OFF_CYCLE_LO);
  localparam logic [31:0] A_HI   = MMIO | 32'(OFF_CYCLE_HI);
  localparam logic [31:0] A_GPIO = MMIO | 32'(OFF_GPIO);
  localparam logic [31:0] A_CD   = MMIO | 32'(OFF_CONS_DATA);
  localparam logic [31:0] A_CS   = MMIO | 32'(OFF_CONS_STAT);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] gpio_out;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH         (1024),
    .FIFO_DEPTH    (16),
    .RAM_BASE_NIB  (4'h0),
    .MMIO_BASE_NIB (4'h8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_out (gpio_out)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.daddr = a; bus.ddata_w = d; bus.d_w = 1'b1; bus.d_r = 1'b0;
    @(posedge clk);
    #1 bus.d_w = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.daddr = a; bus.d_r = 1'b1; bus.d_w = 1'b0;
    #1 d = bus.ddata_r;
    @(posedge clk);
    #1 bus.d_r = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (gpio_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_gpio: got %h expected %h", gpio_out, 32'h0);
    end
    n_checks++;
    if (bus.cons_valid !== 1'b0 || bus.cons_data !== 8'h0) begin
      n_fail++; $display("FAIL reset_cons: got valid=%b data=%h expected 0/00",
                         bus.cons_valid, bus.cons_data);
    end
    bus.daddr = A_CS; bus.d_r = 1'b1;
    #1;
    n_checks++;
    if (bus.ddata_r !== 32'h2) begin
      n_fail++; $display("FAIL reset_status: got %h expected %h", bus.ddata_r, 32'h2);
    end
    bus.daddr = A_LO;
    #1;
    n_checks++;
    if (bus.ddata_r !== 32'h0) begin
      n_fail++; $display("FAIL reset_cycle: got %h expected %h", bus.ddata_r, 32'h0);
    end
    bus.d_r = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] d;
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read(32'h0000_0010, d);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ram_read: got %h expected %h", d, 32'hDEAD_BEEF);
    end
    bus_read(32'h0000_1010, d);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ram_wrap: got %h expected %h", d, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    bus.daddr = 32'h0000_0010; bus.d_r = 1'b0;
    #1;
    n_checks++;
    if (bus.ddata_r !== 32'h0) begin
      n_fail++; $display("FAIL ram_no_rd: got %h expected %h", bus.ddata_r, 32'h0);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    bus_write(32'h0000_0010, 32'h11);
    @(negedge clk);
    bus.daddr = 32'h0000_0010; bus.ddata_w = 32'h22; bus.d_w = 1'b1; bus.d_r = 1'b1;
    #1;
    n_checks++;
    if (bus.ddata_r !== 32'h11) begin
      n_fail++; $display("FAIL rw_old: got %h expected %h", bus.ddata_r, 32'h11);
    end
    @(posedge clk);
    #1 bus.d_w = 1'b0; bus.d_r = 1'b0;
    bus_read(32'h0000_0010, d);
    n_checks++;
    if (d !== 32'h22) begin
      n_fail++; $display("FAIL rw_new: got %h expected %h", d, 32'h22);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] exp_v [4];
    logic [31:0] addr_v [4];
    exp_v  = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h1};
    addr_v = '{A_LO, A_HI, A_LO, A_HI};
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.daddr = A_LO; bus.d_r = 1'b1;
    #1;
    n_checks++;
    if (bus.ddata_r !== 32'd10) begin
      n_fail++; $display("FAIL cycle_10: got %0d expected %0d", bus.ddata_r, 10);
    end
    // Counter at 0xFFFFFFFF; reading LO snapshots HI=0, then the carry shows.
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle_q;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      bus.daddr = addr_v[i];
      #2;
      n_checks++;
      if (bus.ddata_r !== exp_v[i]) begin
        n_fail++; $display("FAIL cycle_carry[%0d]: got %h expected %h", i, bus.ddata_r,
                           exp_v[i]);
      end
    end
    bus.d_r = 1'b0;
  endtask

  task automatic test_gpio();
    logic [31:0] d;
    bus_write(A_GPIO, 32'hA5A5_0001);
    n_checks++;
    if (gpio_out !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL gpio_out: got %h expected %h", gpio_out, 32'hA5A5_0001);
    end
    bus_read(A_GPIO, d);
    n_checks++;
    if (d !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL gpio_read: got %h expected %h", d, 32'hA5A5_0001);
    end
    bus_write(32'h4000_0000, 32'hFFFF_FFFF);
    bus_write(32'h4000_0008, 32'h1234_5678);
    n_checks++;
    if (gpio_out !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL unmapped_wr: got %h expected %h", gpio_out, 32'hA5A5_0001);
    end
    bus_read(32'h4000_0000, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_rd: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_console_overflow();
    logic [31:0] d;
    bus.cons_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus_write(A_CD, 32'h41 + 32'(i));
      if (i < 16) exp_q.push_back(8'(8'h41 + i));
    end
    bus_read(A_CS, d);
    n_checks++;
    if (d !== 32'h85) begin
      n_fail++; $display("FAIL cons_full_status: got %h expected %h", d, 32'h85);
    end
    bus_read(A_CD, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL cons_data_rd: got %h expected %h", d, 32'h0);
    end
    @(negedge clk);
    bus.cons_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      #1;
      n_checks++;
      if (bus.cons_valid !== 1'b1 || bus.cons_data !== e) begin
        n_fail++; $display("FAIL drain[%0d]: got valid=%b data=%h expected 1/%h", i,
                           bus.cons_valid, bus.cons_data, e);
      end
      @(negedge clk);
    end
    bus.cons_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.cons_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got valid=%b expected 0", bus.cons_valid);
    end
    bus_read(A_CS, d);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++; $display("FAIL drain_status: got %h expected %h", d, 32'h3);
    end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(A_CS, 32'h0);
    bus_read(A_CS, d);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++; $display("FAIL ovf_clear: got %h expected %h", d, 32'h2);
    end
    for (int i = 0; i < 16; i++) begin
      bus_write(A_CD, 32'h60 + 32'(i));
      exp_q.push_back(8'(8'h60 + i));
    end
    bus_read(A_CS, d);
    n_checks++;
    if (d !== 32'h84) begin
      n_fail++; $display("FAIL refill_status: got %h expected %h", d, 32'h84);
    end
    @(negedge clk);
    bus.cons_ready = 1'b1;
    bus.daddr = A_CD; bus.ddata_w = 32'h7A; bus.d_w = 1'b1;
    e = exp_q.pop_front();
    exp_q.push_back(8'h7A);
    #1;
    n_checks++;
    if (bus.cons_data !== e) begin
      n_fail++; $display("FAIL popush_head: got %h expected %h", bus.cons_data, e);
    end
    @(posedge clk);
    #1 bus.d_w = 1'b0; bus.cons_ready = 1'b0;
    bus_read(A_CS, d);
    n_checks++;
    if (d !== 32'h84) begin
      n_fail++; $display("FAIL popush_status: got %h expected %h", d, 32'h84);
    end
    @(negedge clk);
    bus.cons_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      #1;
      n_checks++;
      if (bus.cons_valid !== 1'b1 || bus.cons_data !== e) begin
        n_fail++; $display("FAIL popush_drain[%0d]: got valid=%b data=%h expected 1/%h", i,
                           bus.cons_valid, bus.cons_data, e);
      end
      @(negedge clk);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.cons_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.cons_valid);
    end
    bus.daddr = A_CS; bus.d_r = 1'b1;
    #1;
    n_checks++;
    if (bus.ddata_r !== 32'h2) begin
      n_fail++; $display("FAIL rst_status: got %h expected %h", bus.ddata_r, 32'h2);
    end
    exp_q.delete();
    bus.d_r = 1'b0; bus.cons_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.daddr = '0; bus.ddata_w = '0; bus.d_w = 1'b0; bus.d_r = 1'b0;
    bus.cons_ready = 1'b0;
    test_reset();
    test_ram();
    test_same_cycle();
    test_cycle();
    test_gpio();
    test_console_overflow();
    test_full_pop_push();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the core's MEM-stage data port (daddr/ddata_w/d_w/d_r -> ddata_r). It decodes each access to one of two regions:
- a word-addressed RAM;
- a small MMIO block containing a 64-bit cycle counter, a GPIO output register and a console byte FIFO.

The console FIFO drains to an external consumer over a valid/ready handshake. Reads are combinational, so the core captures ddata_r in the same cycle it issues d_r. All writes commit on the clock edge.

Parameters:
DEPTH, 1024, RAM size in 32-bit words; must be a power of 2.
FIFO_DEPTH, 16, console FIFO entries; must be a power of 2, at least 2.
RAM_BASE_NIB, 4'h0, value of daddr[31:28] that selects RAM.
MMIO_BASE_NIB, 4'h8, value of daddr[31:28] that selects MMIO.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
daddr  input  32  byte address from the core's MEM stage
ddata_w  input  32  store data
d_w  input  1  store strobe; commits at posedge
d_r  input  1  load strobe
ddata_r  output  32  load data; combinational
gpio_out  output  32  GPIO output register
cons_data  output  8  console byte at the FIFO head
cons_valid  output  1  FIFO not empty
cons_ready  input  1  consumer accepts the head byte this cycle

Behaviour:
Reset (reset=0, asynchronous):
- RAM contents are not reset.
- Cleared to 0: gpio_out, cycle counter, HI snapshot, FIFO pointers and count, overflow flag.
- cons_valid=0, cons_data=0.

Addressing:
- daddr[1:0] is ignored (word access only).
- RAM index = daddr[log2(DEPTH)+1:2]; accesses wrap modulo DEPTH.
- MMIO offset = daddr[7:0].
- Any other daddr[31:28] value is unmapped: reads return 0, writes are ignored.

ddata_r:
- 0 when d_r=0.
- When d_r=1 and d_w=1 on the same address, ddata_r returns the old value; the new value is visible from the next cycle.

MMIO map (offset, access, function):
- 0x00, RO, CYCLE_LO = counter[31:0]. A read also latches counter[63:32] into the HI snapshot at the edge.
- 0x04, RO, CYCLE_HI = HI snapshot. Reading LO then HI gives a coherent 64-bit value.
- 0x08, RW, GPIO_OUT. A write updates gpio_out at the edge.
- 0x0C, WO, CONSOLE_DATA. A write pushes ddata_w[7:0]; a read returns 0.
- 0x10, R/W, CONSOLE_STATUS. Read = {count[31:8] zero-extended, count in bits [7:3], full[2], empty[1], overflow[0]}. Any write clears overflow.
- Other offsets: read 0, writes ignored.

Cycle counter:
- Increments by 1 every cycle after reset release.
- Wraps 2^64-1 -> 0.

Console FIFO:
- push = CONSOLE_DATA write; pop = cons_valid & cons_ready.
- When full, a push is accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and overflow is set (sticky).
- If an overflow-clear write and a new overflow happen in the same cycle, set wins.
- When empty, push and pop in the same cycle is impossible (cons_valid=0). The pushed byte appears at cons_data with cons_valid=1 on the next cycle (1-cycle latency).
- cons_data and cons_valid are stable while cons_valid=1 and cons_ready=0.
- count range is 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Reset during operation: asynchronous clear as above. The FIFO contents are lost and cons_valid drops immediately.

Decomposition:
Package dmem_pkg holds:
- region nibble constants;
- MMIO offset localparams (OFF_CYCLE_LO, OFF_CYCLE_HI, OFF_GPIO, OFF_CONS_DATA, OFF_CONS_STAT);
- a region_e enum {REG_RAM, REG_MMIO, REG_NONE}.

One sub-module, console_fifo: a synchronous FIFO with push/full/overflow on one side and valid/ready/data on the other, parameterised by depth and width.

Test Plan:
1. RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> 0xDEADBEEF. Read 0x0000_1010 (DEPTH=1024, so the index wraps) -> 0xDEADBEEF. d_r=0 -> ddata_r=0.
2. Same-cycle read/write: RAM[4]=0x11, then d_r=d_w=1 with 0x22 -> ddata_r=0x11 that cycle and 0x22 on the next read.
3. Cycle counter: release reset and read CYCLE_LO at cycle 10 -> 10 (±defined pipeline offset, checked exactly). Force the counter to 0xFFFFFFFF; read LO, then after 1 cycle read HI -> HI=0 (snapshot taken at the LO read), and the counter carries into the upper word.
4. GPIO: write 0xA5A5_0001 to 0x8000_0008 -> gpio_out=0xA5A50001 after the edge; a read returns the same. Unmapped 0x4000_0000 write has no effect.
5. Console: cons_ready=0, push 17 bytes 0x41..0x51 -> status count=16, full=1, overflow=1; byte 0x51 is dropped. Raise cons_ready -> bytes 0x41..0x50 drain in order, one per cycle, then cons_valid=0, empty=1.
6. Full plus simultaneous pop and push: with the FIFO full and cons_ready=1, push 0x7A -> accepted, count stays 16, no overflow. A status write clears overflow; assert reset mid-drain -> cons_valid=0 immediately and count=0.
